ahbl_single_initiator: RTL

//  AHB-Lite manager that turns a valid/ready command stream into single (non-burst)
//  AHB-Lite transfers, one outstanding at a time, and returns the read data or error
//  on a valid/ready response stream. It is the bus-initiating end for the

---
 rtl/ahbl_single_initiator_if.sv | 39 +++
 rtl/ahbl_single_initiator.sv | 97 +++++++++
 2 files changed

// File: rtl/ahbl_single_initiator_if.sv
// Command/response stream plus AHB-Lite manager signals for ahbl_single_initiator.
// master = initiator view, slave = requester + bus-slave view (testbench side).
interface ahbl_single_initiator_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [2:0]        cmd_size_i;
  logic [31:0]       cmd_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic [ADDR_W-1:0] ahbl_haddr_o;
  logic [1:0]        ahbl_htrans_o;
  logic              ahbl_hwrite_o;
  logic [2:0]        ahbl_hsize_o;
  logic [2:0]        ahbl_hburst_o;
  logic [31:0]       ahbl_hwdata_o;
  logic [31:0]       ahbl_hrdata_i;
  logic              ahbl_hready_i;
  logic              ahbl_hresp_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_size_i, cmd_wdata_i, rsp_ready_i,
           ahbl_hrdata_i, ahbl_hready_i, ahbl_hresp_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           ahbl_haddr_o, ahbl_htrans_o, ahbl_hwrite_o, ahbl_hsize_o, ahbl_hburst_o, ahbl_hwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_size_i, cmd_wdata_i, rsp_ready_i,
           ahbl_hrdata_i, ahbl_hready_i, ahbl_hresp_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           ahbl_haddr_o, ahbl_htrans_o, ahbl_hwrite_o, ahbl_hsize_o, ahbl_hburst_o, ahbl_hwdata_o
  );
endinterface

// File: rtl/ahbl_single_initiator.sv
// AHB-Lite single-transfer manager: one valid/ready command becomes one NONSEQ
// SINGLE transfer; read data / error returned on a valid/ready response stream.
module ahbl_single_initiator #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ahbl_single_initiator_if.master bus,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      xfer_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  state_t      state;
  logic [31:0] wdata_q;
  logic        cmd_bad;

  // Illegal size or address not aligned to the transfer size never reaches the bus.
  always_comb begin
    cmd_bad = (bus.cmd_size_i > 3'b010)
            | ((bus.cmd_size_i == 3'b001) & bus.cmd_addr_i[0])
            | ((bus.cmd_size_i == 3'b010) & (|bus.cmd_addr_i[1:0]));
  end

  assign bus.cmd_ready_o   = (state == S_IDLE) & ~rst_i;
  assign bus.ahbl_hburst_o = 3'b000;
  assign busy_o            = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= S_IDLE;
      wdata_q           <= '0;
      bus.ahbl_haddr_o  <= '0;
      bus.ahbl_htrans_o <= HT_IDLE;
      bus.ahbl_hwrite_o <= 1'b0;
      bus.ahbl_hsize_o  <= '0;
      bus.ahbl_hwdata_o <= '0;
      bus.rsp_valid_o   <= 1'b0;
      bus.rsp_rdata_o   <= '0;
      bus.rsp_err_o     <= 1'b0;
      xfer_cnt_o        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_valid_i) begin
            if (cmd_bad) begin
              state           <= S_RESP;
              bus.rsp_valid_o <= 1'b1;
              bus.rsp_err_o   <= 1'b1;
              bus.rsp_rdata_o <= '0;
            end else begin
              state             <= S_ADDR;
              bus.ahbl_haddr_o  <= bus.cmd_addr_i;
              bus.ahbl_hwrite_o <= bus.cmd_write_i;
              bus.ahbl_hsize_o  <= bus.cmd_size_i;
              bus.ahbl_htrans_o <= HT_NONSEQ;
              wdata_q           <= bus.cmd_wdata_i;
            end
          end
        end
        S_ADDR: begin
          if (bus.ahbl_hready_i) begin
            state             <= S_DATA;
            bus.ahbl_htrans_o <= HT_IDLE;
            bus.ahbl_hwdata_o <= bus.ahbl_hwrite_o ? wdata_q : '0;
          end
        end
        S_DATA: begin
          // First ERROR cycle (hready low) just waits; the second one completes.
          if (bus.ahbl_hready_i) begin
            state             <= S_RESP;
            bus.ahbl_hwdata_o <= '0;
            bus.rsp_valid_o   <= 1'b1;
            bus.rsp_err_o     <= bus.ahbl_hresp_i;
            bus.rsp_rdata_o   <= (!bus.ahbl_hwrite_o && !bus.ahbl_hresp_i) ? bus.ahbl_hrdata_i : '0;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            state           <= S_IDLE;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_rdata_o <= '0;
            xfer_cnt_o      <= xfer_cnt_o + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
